// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes, master FSM encoding and
// the saturating increment used by the error counter.
package axil_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [2:0] ST_INIT  = 3'd0;
    localparam logic [2:0] ST_IDLE  = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_WRESP = 3'd3;
    localparam logic [2:0] ST_READ  = 3'd4;
    localparam logic [2:0] ST_RRESP = 3'd5;
    localparam logic [2:0] ST_RSP   = 3'd6;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/axil_master_if.sv
// AXI4-Lite bus bundle with master and slave views.
interface axil_master_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axil_master.sv
// AXI4-Lite initiator: one register request at a time, AW and W tracked
// independently, response returned on a valid/ready port.
module axil_master
    import axil_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_we,
    input  logic [AXI_ADDR_WIDTH-1:0]   req_addr,
    input  logic [AXI_DATA_WIDTH-1:0]   req_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] req_wstrb,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                  rsp_resp,
    output logic                        busy,
    output logic [15:0]                 err_count,
    axil_master_if.master               m_axi
);

    logic [2:0]                  state_r;
    logic                        req_ready_r;
    logic                        busy_r;
    logic                        awvalid_r;
    logic                        wvalid_r;
    logic                        bready_r;
    logic                        arvalid_r;
    logic                        rready_r;
    logic                        aw_done_r;
    logic                        w_done_r;
    logic [AXI_ADDR_WIDTH-1:0]   addr_r;
    logic [AXI_DATA_WIDTH-1:0]   wdata_r;
    logic [AXI_DATA_WIDTH/8-1:0] wstrb_r;
    logic                        rsp_valid_r;
    logic [AXI_DATA_WIDTH-1:0]   rsp_rdata_r;
    logic [1:0]                  rsp_resp_r;
    logic [15:0]                 err_count_r;

    logic aw_hs_s;
    logic w_hs_s;
    logic aw_fin_s;
    logic w_fin_s;

    assign aw_hs_s  = awvalid_r & m_axi.awready;
    assign w_hs_s   = wvalid_r & m_axi.wready;
    assign aw_fin_s = aw_done_r | aw_hs_s;
    assign w_fin_s  = w_done_r | w_hs_s;

    assign m_axi.awaddr  = addr_r;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awvalid = awvalid_r;
    assign m_axi.wdata   = wdata_r;
    assign m_axi.wstrb   = wstrb_r;
    assign m_axi.wvalid  = wvalid_r;
    assign m_axi.bready  = bready_r;
    assign m_axi.araddr  = addr_r;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arvalid = arvalid_r;
    assign m_axi.rready  = rready_r;

    assign req_ready = req_ready_r;
    assign busy      = busy_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_resp  = rsp_resp_r;
    assign err_count = err_count_r;

    // Master FSM; every output is a flop updated on the transition that defines it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= ST_INIT;
            req_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            awvalid_r   <= 1'b0;
            wvalid_r    <= 1'b0;
            bready_r    <= 1'b0;
            arvalid_r   <= 1'b0;
            rready_r    <= 1'b0;
            aw_done_r   <= 1'b0;
            w_done_r    <= 1'b0;
            addr_r      <= {AXI_ADDR_WIDTH{1'b0}};
            wdata_r     <= {AXI_DATA_WIDTH{1'b0}};
            wstrb_r     <= {(AXI_DATA_WIDTH/8){1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {AXI_DATA_WIDTH{1'b0}};
            rsp_resp_r  <= 2'b00;
            err_count_r <= 16'h0000;
        end else begin
            case (state_r)
                ST_INIT: begin
                    state_r     <= ST_IDLE;
                    req_ready_r <= 1'b1;
                    busy_r      <= 1'b0;
                end
                ST_IDLE: begin
                    if (req_valid && req_ready_r) begin
                        req_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        addr_r      <= req_addr;
                        if (req_we) begin
                            wdata_r   <= req_wdata;
                            wstrb_r   <= req_wstrb;
                            awvalid_r <= 1'b1;
                            wvalid_r  <= 1'b1;
                            aw_done_r <= 1'b0;
                            w_done_r  <= 1'b0;
                            state_r   <= ST_WRITE;
                        end else begin
                            arvalid_r <= 1'b1;
                            state_r   <= ST_READ;
                        end
                    end
                end
                ST_WRITE: begin
                    if (aw_hs_s) begin
                        awvalid_r <= 1'b0;
                        aw_done_r <= 1'b1;
                    end
                    if (w_hs_s) begin
                        wvalid_r <= 1'b0;
                        w_done_r <= 1'b1;
                    end
                    // bready only once both address and data have been taken
                    if (aw_fin_s && w_fin_s) begin
                        bready_r <= 1'b1;
                        state_r  <= ST_WRESP;
                    end
                end
                ST_WRESP: begin
                    if (m_axi.bvalid) begin
                        bready_r    <= 1'b0;
                        rsp_resp_r  <= m_axi.bresp;
                        rsp_rdata_r <= {AXI_DATA_WIDTH{1'b0}};
                        rsp_valid_r <= 1'b1;
                        state_r     <= ST_RSP;
                        if (m_axi.bresp != AXI_RESP_OKAY) begin
                            err_count_r <= sat_inc16(err_count_r);
                        end
                    end
                end
                ST_READ: begin
                    if (m_axi.arready) begin
                        arvalid_r <= 1'b0;
                        rready_r  <= 1'b1;
                        state_r   <= ST_RRESP;
                    end
                end
                ST_RRESP: begin
                    if (m_axi.rvalid) begin
                        rready_r    <= 1'b0;
                        rsp_resp_r  <= m_axi.rresp;
                        rsp_rdata_r <= m_axi.rdata;
                        rsp_valid_r <= 1'b1;
                        state_r     <= ST_RSP;
                        if (m_axi.rresp != AXI_RESP_OKAY) begin
                            err_count_r <= sat_inc16(err_count_r);
                        end
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        req_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r     <= ST_INIT;
                    req_ready_r <= 1'b0;
                    busy_r      <= 1'b1;
                    awvalid_r   <= 1'b0;
                    wvalid_r    <= 1'b0;
                    bready_r    <= 1'b0;
                    arvalid_r   <= 1'b0;
                    rready_r    <= 1'b0;
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axil_master.sv
// Directed bench for axil_master with a small AXI4-Lite slave model whose
// per-channel ready/valid delays and response codes are set by each test.
module tb_axil_master;
    import axil_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [15:0] req_addr = 16'h0000;
    logic [31:0] req_wdata = 32'h0;
    logic [3:0]  req_wstrb = 4'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        busy;
    logic [15:0] err_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    axil_master_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();

    axil_master #(.AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(16)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .busy(busy), .err_count(err_count),
        .m_axi(bus)
    );

    // ---------------- slave model ----------------
    int aw_delay = 0, w_delay = 0, b_delay = 0, r_delay = 0;
    logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic aw_got = 1'b0, w_got = 1'b0, b_pend = 1'b0, r_pend = 1'b0;
    int aw_wait = 0, w_wait = 0, b_wait = 0, r_wait = 0;
    int aw_beats = 0, w_beats = 0, b_beats = 0, r_beats = 0;
    logic [15:0] aw_addr_q = 16'h0;
    logic [31:0] w_data_q = 32'h0, r_data_q = 32'h0;
    logic [3:0]  w_strb_q = 4'h0;
    logic [31:0] mem [0:15];
    logic aw_hs, w_hs;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;

    assign bus.awready = bus.awvalid && !aw_got && (aw_wait >= aw_delay);
    assign bus.wready  = bus.wvalid && !w_got && (w_wait >= w_delay);
    assign bus.bvalid  = b_pend && (b_wait >= b_delay);
    assign bus.bresp   = bresp_cfg;
    assign bus.arready = bus.arvalid && !r_pend;
    assign bus.rvalid  = r_pend && (r_wait >= r_delay);
    assign bus.rdata   = r_data_q;
    assign bus.rresp   = rresp_cfg;
    assign aw_hs   = bus.awvalid && bus.awready;
    assign w_hs    = bus.wvalid && bus.wready;
    assign wr_addr = aw_got ? aw_addr_q : bus.awaddr;
    assign wr_data = w_got ? w_data_q : bus.wdata;
    assign wr_strb = w_got ? w_strb_q : bus.wstrb;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
            aw_wait <= 0; w_wait <= 0; b_wait <= 0; r_wait <= 0;
        end else begin
            aw_wait <= (bus.awvalid && !aw_hs && !aw_got) ? aw_wait + 1 : 0;
            w_wait  <= (bus.wvalid && !w_hs && !w_got) ? w_wait + 1 : 0;
            if (b_pend) b_wait <= b_wait + 1;
            if (aw_hs) begin aw_beats <= aw_beats + 1; aw_addr_q <= bus.awaddr; end
            if (w_hs) begin w_beats <= w_beats + 1; w_data_q <= bus.wdata; w_strb_q <= bus.wstrb; end
            if ((aw_got || aw_hs) && (w_got || w_hs)) begin
                for (int i = 0; i < 4; i++)
                    if (wr_strb[i]) mem[wr_addr[5:2]][8*i +: 8] <= wr_data[8*i +: 8];
                aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b1; b_wait <= 0;
            end else begin
                if (aw_hs) aw_got <= 1'b1;
                if (w_hs) w_got <= 1'b1;
            end
            if (bus.bvalid && bus.bready) begin b_pend <= 1'b0; b_beats <= b_beats + 1; end
            if (bus.arvalid && bus.arready) begin
                r_pend <= 1'b1; r_wait <= 0; r_data_q <= mem[bus.araddr[5:2]];
            end else if (r_pend) begin
                r_wait <= r_wait + 1;
            end
            if (bus.rvalid && bus.rready) begin r_pend <= 1'b0; r_beats <= r_beats + 1; end
        end
    end

    // ---------------- request helpers (called at a negedge) ----------------
    task automatic start_req(input logic we, input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        logic acc;
        req_we = we; req_addr = a; req_wdata = d; req_wstrb = s; req_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            if (req_ready) acc = 1'b1;
            else @(negedge clk);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) lat = -1;
    endtask

    task automatic ack_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic do_txn(input logic we, input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                          output int lat, output logic [31:0] rd, output logic [1:0] rs);
        start_req(we, a, d, s);
        wait_rsp(lat);
        rd = rsp_rdata;
        rs = rsp_resp;
        if (lat > 0) ack_rsp();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({req_ready, busy, rsp_valid, bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready} !== 8'b0100_0000) begin
            fails++; $display("FAIL reset_ctrl: got %b expected 01000000",
                {req_ready, busy, rsp_valid, bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready});
        end
        tests++;
        if (err_count !== 16'h0 || rsp_rdata !== 32'h0 || rsp_resp !== 2'b00) begin
            fails++; $display("FAIL reset_data: got cnt=%h rdata=%h resp=%b expected zeros", err_count, rsp_rdata, rsp_resp);
        end
        resetn = 1'b1;
        @(negedge clk);
        tests++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL reset_to_idle: got ready=%b busy=%b expected 1 0", req_ready, busy);
        end
    endtask

    task automatic test_write();
        int lat, aw0, w0;
        logic [31:0] rd;
        logic [1:0] rs;
        aw0 = aw_beats; w0 = w_beats;
        do_txn(1'b1, 16'h0000, 32'h0000_00F7, 4'hF, lat, rd, rs);
        tests++;
        if (lat !== 3) begin fails++; $display("FAIL write_latency: got %0d expected 3", lat); end
        tests++;
        if (rs !== AXI_RESP_OKAY || rd !== 32'h0) begin
            fails++; $display("FAIL write_rsp: got resp=%b rdata=%h expected 00 0", rs, rd);
        end
        tests++;
        if (aw_beats - aw0 !== 1 || w_beats - w0 !== 1 || mem[0] !== 32'h0000_00F7) begin
            fails++; $display("FAIL write_beats: got aw=%0d w=%0d mem=%h expected 1 1 000000f7",
                aw_beats - aw0, w_beats - w0, mem[0]);
        end
        tests++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || err_count !== 16'h0) begin
            fails++; $display("FAIL write_idle: got ready=%b busy=%b cnt=%h expected 1 0 0", req_ready, busy, err_count);
        end
    endtask

    task automatic test_readback();
        int lat, r0;
        logic [31:0] rd;
        logic [1:0] rs;
        do_txn(1'b1, 16'h0000, 32'h0000_00B2, 4'hF, lat, rd, rs);
        r0 = r_beats;
        do_txn(1'b0, 16'h0000, 32'h0, 4'h0, lat, rd, rs);
        tests++;
        if (lat !== 3 || rd !== 32'h0000_00B2 || rs !== AXI_RESP_OKAY || r_beats - r0 !== 1) begin
            fails++; $display("FAIL readback: got lat=%0d rdata=%h resp=%b beats=%0d expected 3 000000b2 00 1",
                lat, rd, rs, r_beats - r0);
        end
        do_txn(1'b1, 16'h0004, 32'hAABB_CCDD, 4'hF, lat, rd, rs);
        do_txn(1'b1, 16'h0004, 32'h1122_3344, 4'b0101, lat, rd, rs);
        start_req(1'b0, 16'h0004, 32'h0, 4'h0);
        tests++;
        if (bus.arvalid !== 1'b1 || bus.araddr !== 16'h0004 || bus.arprot !== 3'b000) begin
            fails++; $display("FAIL ar_addr: got v=%b addr=%h prot=%b expected 1 0004 000", bus.arvalid, bus.araddr, bus.arprot);
        end
        wait_rsp(lat);
        rd = rsp_rdata;
        if (lat > 0) ack_rsp();
        tests++;
        if (rd !== 32'hAA22_CC44) begin fails++; $display("FAIL strobe_read: got %h expected aa22cc44", rd); end
    endtask

    task automatic test_skew();
        int lat, early, aw0, w0, b0;
        for (int k = 0; k < 2; k++) begin
            aw_delay = (k == 0) ? 4 : 0;
            w_delay  = (k == 0) ? 0 : 4;
            aw0 = aw_beats; w0 = w_beats; b0 = b_beats;
            start_req(1'b1, 16'h0008, 32'h5A5A_0000 + k, 4'hF);
            tests++;
            if ({bus.awvalid, bus.wvalid} !== 2'b11) begin
                fails++; $display("FAIL skew%0d_start: got %b expected 11", k, {bus.awvalid, bus.wvalid});
            end
            @(negedge clk);
            tests++;
            if ({bus.awvalid, bus.wvalid, bus.bready} !== ((k == 0) ? 3'b100 : 3'b010)) begin
                fails++; $display("FAIL skew%0d_hold: got %b expected %b", k,
                    {bus.awvalid, bus.wvalid, bus.bready}, (k == 0) ? 3'b100 : 3'b010);
            end
            lat = 2; early = 0;
            while (!rsp_valid && lat < 60) begin
                if (bus.bready && (bus.awvalid || bus.wvalid)) early++;
                @(negedge clk);
                lat++;
            end
            tests++;
            if (lat !== 7 || early !== 0) begin
                fails++; $display("FAIL skew%0d_order: got lat=%0d early_bready=%0d expected 7 0", k, lat, early);
            end
            if (rsp_valid) ack_rsp();
            repeat (3) @(negedge clk);
            tests++;
            if (rsp_valid !== 1'b0 || aw_beats - aw0 !== 1 || w_beats - w0 !== 1 || b_beats - b0 !== 1) begin
                fails++; $display("FAIL skew%0d_single: got rsp=%b aw=%0d w=%0d b=%0d expected 0 1 1 1", k,
                    rsp_valid, aw_beats - aw0, w_beats - w0, b_beats - b0);
            end
        end
        aw_delay = 0; w_delay = 0;
    endtask

    task automatic test_backpressure();
        int lat, bad;
        for (int k = 0; k < 2; k++) begin
            b_delay = 5; r_delay = 5;
            start_req(k == 0, 16'h000C, 32'hCAFE_0001, 4'hF);
            wait_rsp(lat);
            tests++;
            if (lat !== 8) begin fails++; $display("FAIL bp%0d_latency: got %0d expected 8", k, lat); end
            bad = 0;
            repeat (10) begin
                @(negedge clk);
                if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || busy !== 1'b1 || rsp_resp !== 2'b00 ||
                    rsp_rdata !== ((k == 0) ? 32'h0 : 32'hCAFE_0001)) bad++;
            end
            tests++;
            if (bad !== 0) begin fails++; $display("FAIL bp%0d_stable: got %0d unstable cycles expected 0", k, bad); end
            if (rsp_valid) ack_rsp();
        end
        b_delay = 0; r_delay = 0;
    endtask

    task automatic test_errors();
        int lat;
        logic [31:0] rd;
        logic [1:0] rs;
        bresp_cfg = AXI_RESP_SLVERR;
        for (int k = 0; k < 3; k++) begin
            do_txn(1'b1, 16'h0010, 32'h0, 4'hF, lat, rd, rs);
            tests++;
            if (rs !== 2'b10) begin fails++; $display("FAIL slverr%0d: got %b expected 10", k, rs); end
        end
        bresp_cfg = AXI_RESP_OKAY;
        tests++;
        if (err_count !== 16'd3) begin fails++; $display("FAIL err_count3: got %0d expected 3", err_count); end
        rresp_cfg = AXI_RESP_DECERR;
        for (int k = 0; k < 2; k++) begin
            do_txn(1'b0, 16'h0014, 32'h0, 4'h0, lat, rd, rs);
            tests++;
            if (rs !== 2'b11) begin fails++; $display("FAIL decerr%0d: got %b expected 11", k, rs); end
        end
        rresp_cfg = AXI_RESP_OKAY;
        do_txn(1'b0, 16'h0000, 32'h0, 4'h0, lat, rd, rs);
        tests++;
        if (err_count !== 16'd5) begin fails++; $display("FAIL err_count5: got %0d expected 5", err_count); end
    endtask

    task automatic test_saturation();
        int lat;
        logic [31:0] rd;
        logic [1:0] rs;
        force dut.err_count_r = 16'hFFFE;
        @(negedge clk);
        release dut.err_count_r;
        @(negedge clk);
        tests++;
        if (err_count !== 16'hFFFE) begin fails++; $display("FAIL sat_preload: got %h expected fffe", err_count); end
        bresp_cfg = AXI_RESP_SLVERR;
        do_txn(1'b1, 16'h0018, 32'h0, 4'hF, lat, rd, rs);
        tests++;
        if (err_count !== 16'hFFFF) begin fails++; $display("FAIL sat_first: got %h expected ffff", err_count); end
        do_txn(1'b1, 16'h0018, 32'h0, 4'hF, lat, rd, rs);
        tests++;
        if (err_count !== 16'hFFFF) begin fails++; $display("FAIL sat_hold: got %h expected ffff", err_count); end
        bresp_cfg = AXI_RESP_OKAY;
    endtask

    task automatic test_reset_midop();
        int lat, seen;
        logic [31:0] rd;
        logic [1:0] rs;
        b_delay = 8;
        start_req(1'b1, 16'h001C, 32'h1234_5678, 4'hF);
        @(negedge clk);
        tests++;
        if (bus.bready !== 1'b1) begin fails++; $display("FAIL midop_wresp: got bready=%b expected 1", bus.bready); end
        #2 resetn = 1'b0;
        #1;
        tests++;
        if ({bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready, rsp_valid, req_ready, busy} !== 8'b0000_0001 ||
            err_count !== 16'h0) begin
            fails++; $display("FAIL midop_async: got %b cnt=%h expected 00000001 0000",
                {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready, rsp_valid, req_ready, busy}, err_count);
        end
        @(negedge clk);
        resetn = 1'b1;
        b_delay = 0;
        @(negedge clk);
        tests++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL midop_idle: got ready=%b busy=%b expected 1 0", req_ready, busy);
        end
        seen = 0;
        repeat (5) begin
            if (rsp_valid) seen++;
            @(negedge clk);
        end
        tests++;
        if (seen !== 0) begin fails++; $display("FAIL midop_no_rsp: got %0d rsp cycles expected 0", seen); end
        do_txn(1'b1, 16'h001C, 32'h0000_0001, 4'hF, lat, rd, rs);
        tests++;
        if (lat !== 3 || rs !== 2'b00 || err_count !== 16'h0) begin
            fails++; $display("FAIL midop_recover: got lat=%0d resp=%b cnt=%h expected 3 00 0000", lat, rs, err_count);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_write();
        test_readback();
        test_skew();
        test_backpressure();
        test_errors();
        test_saturation();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
